// File: rtl/score_hud.sv
// Score and lives heads-up display for the maze game: edge-detected controls, a five-state game
// FSM, a saturating 4-digit BCD score and active-low seven-segment drivers.
module score_hud #(
    parameter int unsigned PELLET_PTS = 1,
    parameter int unsigned LIVES      = 3,
    parameter int unsigned DEATH_HOLD = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       pellet,
    input  logic       caught,
    input  logic       gamewin,
    output logic [6:0] HEX0,
    output logic [6:0] HEX1,
    output logic [6:0] HEX2,
    output logic [6:0] HEX3,
    output logic [6:0] HEX4,
    output logic [6:0] HEX5,
    output logic [1:0] lives,
    output logic [2:0] state,
    output logic       respawn,
    output logic       game_over
);

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StPlay  = 3'd1,
        StDying = 3'd2,
        StWin   = 3'd3,
        StOver  = 3'd4
    } state_e;

    localparam logic [3:0] Pts       = 4'(PELLET_PTS);
    localparam logic [1:0] LivesInit = 2'(LIVES);
    localparam int unsigned HoldW    = (DEATH_HOLD > 1) ? $clog2(DEATH_HOLD) : 1;
    localparam logic [HoldW-1:0] HoldInit = HoldW'(DEATH_HOLD - 1);

    state_e           state_q;
    logic [15:0]      score_q;
    logic [15:0]      score_sum;
    logic [15:0]      score_add;
    logic [1:0]       lives_q;
    logic [HoldW-1:0] hold_q;
    logic [2:0]       in_q;
    logic [2:0]       in_qq;
    logic [1:0]       arm_q;
    logic             respawn_q;
    logic             game_over_q;
    logic             start_rise;
    logic             pellet_rise;
    logic             caught_rise;

    // arm_q[1] only rises once in_qq holds a real sample, so a level held through reset is no edge
    assign start_rise  = in_q[0] & ~in_qq[0] & arm_q[1];
    assign pellet_rise = in_q[1] & ~in_qq[1] & arm_q[1];
    assign caught_rise = in_q[2] & ~in_qq[2] & arm_q[1];

    always_comb begin : bcd_add
        logic       carry;
        logic [4:0] sum;
        carry     = 1'b0;
        sum       = '0;
        score_sum = score_q;
        for (int d = 0; d < 4; d++) begin
            sum = {1'b0, score_q[4*d +: 4]} + {4'b0, carry} + ((d == 0) ? {1'b0, Pts} : 5'd0);
            if (sum > 5'd9) begin
                score_sum[4*d +: 4] = 4'(sum - 5'd10);
                carry               = 1'b1;
            end else begin
                score_sum[4*d +: 4] = sum[3:0];
                carry               = 1'b0;
            end
        end
        // A carry out of the thousands digit means the sum passed 9999
        score_add = carry ? 16'h9999 : score_sum;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            score_q     <= '0;
            lives_q     <= LivesInit;
            hold_q      <= '0;
            in_q        <= '0;
            in_qq       <= '0;
            arm_q       <= '0;
            respawn_q   <= 1'b0;
            game_over_q <= 1'b0;
        end else begin
            in_q      <= {caught, pellet, start};
            in_qq     <= in_q;
            arm_q     <= {arm_q[0], 1'b1};
            respawn_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start_rise) begin
                        score_q <= '0;
                        lives_q <= LivesInit;
                        state_q <= StPlay;
                    end
                end
                StPlay: begin
                    if (pellet_rise) score_q <= score_add;
                    if (gamewin) begin
                        state_q <= StWin;
                    end else if (caught_rise) begin
                        lives_q <= lives_q - 2'd1;
                        if (lives_q == 2'd1) begin
                            state_q     <= StOver;
                            game_over_q <= 1'b1;
                        end else begin
                            state_q   <= StDying;
                            hold_q    <= HoldInit;
                            respawn_q <= (HoldInit == '0);
                        end
                    end
                end
                StDying: begin
                    // respawn is raised for the final DYING cycle, when hold_q sits at zero
                    if (hold_q == '0) begin
                        state_q <= StPlay;
                    end else begin
                        hold_q    <= hold_q - HoldW'(1);
                        respawn_q <= (hold_q == HoldW'(1));
                    end
                end
                StWin, StOver: begin
                    if (start_rise) begin
                        score_q     <= '0;
                        lives_q     <= LivesInit;
                        state_q     <= StPlay;
                        game_over_q <= 1'b0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    assign HEX0 = seg7(score_q[3:0]);
    assign HEX1 = (score_q[15:4] == '0)  ? 7'b1111111 : seg7(score_q[7:4]);
    assign HEX2 = (score_q[15:8] == '0)  ? 7'b1111111 : seg7(score_q[11:8]);
    assign HEX3 = (score_q[15:12] == '0) ? 7'b1111111 : seg7(score_q[15:12]);
    assign HEX4 = 7'b1111111;
    assign HEX5 = seg7({2'b00, lives_q});

    assign lives     = lives_q;
    assign state     = state_q;
    assign respawn   = respawn_q;
    assign game_over = game_over_q;

endmodule

// File: tb/tb_score_hud.sv
// Bench for score_hud: two instances (default and PELLET_PTS=9/LIVES=2/DEATH_HOLD=1) share
// stimulus and are checked against an integer-level game model.
module tb_score_hud;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0, pellet = 1'b0, caught = 1'b0, gamewin = 1'b0;

    logic [6:0] h0[2], h1[2], h2[2], h3[2], h4[2], h5[2];
    logic [1:0] lv[2];
    logic [2:0] st[2];
    logic       rs[2], go[2];

    int vectors = 0;
    int miscompares = 0;

    int pts[2] = '{1, 9};
    int lvs[2] = '{3, 2};
    int dh[2]  = '{8, 1};

    int m_state[2], m_score[2], m_lives[2], m_spent[2];
    logic [2:0] s1, s2;
    int n_samp;

    always #5 clk = ~clk;

    score_hud #(.PELLET_PTS(1), .LIVES(3), .DEATH_HOLD(8)) dut0 (
        .clk(clk), .reset(reset), .start(start), .pellet(pellet), .caught(caught),
        .gamewin(gamewin), .HEX0(h0[0]), .HEX1(h1[0]), .HEX2(h2[0]), .HEX3(h3[0]),
        .HEX4(h4[0]), .HEX5(h5[0]), .lives(lv[0]), .state(st[0]), .respawn(rs[0]),
        .game_over(go[0])
    );

    score_hud #(.PELLET_PTS(9), .LIVES(2), .DEATH_HOLD(1)) dut1 (
        .clk(clk), .reset(reset), .start(start), .pellet(pellet), .caught(caught),
        .gamewin(gamewin), .HEX0(h0[1]), .HEX1(h1[1]), .HEX2(h2[1]), .HEX3(h3[1]),
        .HEX4(h4[1]), .HEX5(h5[1]), .lives(lv[1]), .state(st[1]), .respawn(rs[1]),
        .game_over(go[1])
    );

    function automatic logic [6:0] seg(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    // Digit k of the decimal score; upper digits are blank while the score is below 10^k
    function automatic logic [6:0] exp_hex(input int score, input int k);
        int p;
        p = 1;
        for (int j = 0; j < k; j++) p = p * 10;
        if (k > 0 && score < p) return 7'b1111111;
        return seg((score / p) % 10);
    endfunction

    function automatic logic exp_rs(input int i);
        return (m_state[i] == 2) && (m_spent[i] == dh[i] - 1);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_state[i] = 0;
            m_score[i] = 0;
            m_lives[i] = lvs[i];
            m_spent[i] = 0;
        end
        s1 = '0;
        s2 = '0;
        n_samp = 0;
    endtask

    task automatic model_step();
        logic [2:0] cur, rise;
        cur  = {caught, pellet, start};
        rise = (n_samp >= 2) ? (s1 & ~s2) : 3'b000;
        for (int i = 0; i < 2; i++) begin
            case (m_state[i])
                0: if (rise[0]) begin
                    m_score[i] = 0; m_lives[i] = lvs[i]; m_state[i] = 1;
                end
                1: begin
                    if (rise[1])
                        m_score[i] = (m_score[i] + pts[i] > 9999) ? 9999 : m_score[i] + pts[i];
                    if (gamewin) m_state[i] = 3;
                    else if (rise[2]) begin
                        m_lives[i]--;
                        if (m_lives[i] == 0) m_state[i] = 4;
                        else begin m_state[i] = 2; m_spent[i] = 0; end
                    end
                end
                2: begin
                    m_spent[i]++;
                    if (m_spent[i] == dh[i]) m_state[i] = 1;
                end
                default: if (rise[0]) begin
                    m_score[i] = 0; m_lives[i] = lvs[i]; m_state[i] = 1;
                end
            endcase
        end
        s2 = s1;
        s1 = cur;
        if (n_samp < 2) n_samp++;
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset) model_step();
        @(negedge clk);
    endtask

    task automatic press(input int which);
        case (which)
            0: start = 1'b1;
            1: pellet = 1'b1;
            default: caught = 1'b1;
        endcase
        tick();
        start = 1'b0; pellet = 1'b0; caught = 1'b0;
        tick();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        tick();
        tick();
    endtask

    task automatic new_game();
        do_reset();
        press(0);
    endtask

    task automatic test_reset();
        #1 reset = 1'b0;
        model_reset();
        #1;
        for (int i = 0; i < 2; i++) begin
            vectors++;
            if (h0[i] !== 7'b1000000) begin miscompares++;
                $display("FAIL rst_hex0 dut%0d got %b want 1000000", i, h0[i]); end
            vectors++;
            if ({h1[i], h2[i], h3[i], h4[i]} !== {4{7'b1111111}}) begin miscompares++;
                $display("FAIL rst_blank dut%0d got %b %b %b %b", i, h1[i], h2[i], h3[i], h4[i]); end
            vectors++;
            if (h5[i] !== seg(lvs[i])) begin miscompares++;
                $display("FAIL rst_hex5 dut%0d got %b want %b", i, h5[i], seg(lvs[i])); end
            vectors++;
            if ({st[i], rs[i], go[i]} !== 5'b0) begin miscompares++;
                $display("FAIL rst_state dut%0d got st=%0d rs=%b go=%b want 0 0 0", i, st[i], rs[i], go[i]); end
        end
        vectors++;
        if (h5[0] !== 7'b0110000) begin miscompares++;
            $display("FAIL rst_lives3 got %b want 0110000", h5[0]); end
        @(negedge clk);
        start = 1'b1; pellet = 1'b1; caught = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        repeat (4) tick();
        for (int i = 0; i < 2; i++) begin
            vectors++;
            if (st[i] !== 3'd0) begin miscompares++;
                $display("FAIL held_through_reset dut%0d got st=%0d want 0", i, st[i]); end
        end
        start = 1'b0; pellet = 1'b0; caught = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_pellets();
        new_game();
        repeat (12) press(1);
        tick();
        vectors++;
        if (st[0] !== 3'd1) begin miscompares++;
            $display("FAIL pel12_state got %0d want 1", st[0]); end
        vectors++;
        if ({h3[0], h2[0], h1[0], h0[0]} !== {7'b1111111, 7'b1111111, 7'b1111001, 7'b0100100})
        begin miscompares++;
            $display("FAIL pel12_hex got %b %b %b %b want blank blank 1111001 0100100",
                     h3[0], h2[0], h1[0], h0[0]); end
        vectors++;
        if ({h3[1], h2[1], h1[1], h0[1]} !== {exp_hex(m_score[1], 3), exp_hex(m_score[1], 2),
                                             exp_hex(m_score[1], 1), exp_hex(m_score[1], 0)})
        begin miscompares++;
            $display("FAIL pel12_pts9 got %b %b %b %b for score %0d",
                     h3[1], h2[1], h1[1], h0[1], m_score[1]); end
    endtask

    task automatic test_death();
        int dying, resp, n;
        new_game();
        press(2);
        vectors++;
        if ({st[0], lv[0], h5[0]} !== {3'd2, 2'd2, 7'b0100100}) begin miscompares++;
            $display("FAIL death_entry got st=%0d lives=%0d hex5=%b want 2 2 0100100",
                     st[0], lv[0], h5[0]); end
        dying = 0; resp = 0; n = 0;
        while (st[0] == 3'd2 && n < 30) begin
            dying++;
            if (rs[0]) resp++;
            tick();
            n++;
        end
        if (rs[0]) resp++;
        vectors++;
        if (dying != 8) begin miscompares++;
            $display("FAIL death_hold got %0d cycles want 8", dying); end
        vectors++;
        if (resp != 1) begin miscompares++;
            $display("FAIL death_respawn got %0d pulses want 1", resp); end
        vectors++;
        if (st[0] !== 3'd1) begin miscompares++;
            $display("FAIL death_return got st=%0d want 1", st[0]); end
        vectors++;
        if (st[1] !== 3'(m_state[1]) || lv[1] !== 2'(m_lives[1])) begin miscompares++;
            $display("FAIL death_dut1 got st=%0d lives=%0d want %0d %0d",
                     st[1], lv[1], m_state[1], m_lives[1]); end
    endtask

    task automatic test_game_over();
        int n;
        new_game();
        repeat (3) begin
            press(2);
            n = 0;
            while (st[0] == 3'd2 && n < 40) begin tick(); n++; end
            vectors++;
            if (n >= 40) begin miscompares++;
                $display("FAIL over_dying_timeout got st=%0d want exit from 2", st[0]); end
        end
        for (int i = 0; i < 2; i++) begin
            vectors++;
            if ({st[i], lv[i], go[i]} !== {3'd4, 2'd0, 1'b1}) begin miscompares++;
                $display("FAIL over_state dut%0d got st=%0d lives=%0d go=%b want 4 0 1",
                         i, st[i], lv[i], go[i]); end
        end
        press(0);
        vectors++;
        if ({st[0], lv[0], go[0], h1[0], h0[0]} !== {3'd1, 2'd3, 1'b0, 7'b1111111, 7'b1000000})
        begin miscompares++;
            $display("FAIL over_restart got st=%0d lives=%0d go=%b hex1=%b hex0=%b",
                     st[0], lv[0], go[0], h1[0], h0[0]); end
        vectors++;
        if (lv[1] !== 2'd2) begin miscompares++;
            $display("FAIL over_restart_dut1 got lives=%0d want 2", lv[1]); end
    endtask

    task automatic test_win_priority();
        int n, resp;
        new_game();
        repeat (2) begin
            press(2);
            n = 0;
            while (st[0] == 3'd2 && n < 40) begin tick(); n++; end
        end
        gamewin = 1'b1; caught = 1'b1;
        resp = 0;
        tick();
        caught = 1'b0;
        repeat (4) begin if (rs[0]) resp++; tick(); end
        gamewin = 1'b0;
        vectors++;
        if ({st[0], lv[0], go[0]} !== {3'd3, 2'd1, 1'b0}) begin miscompares++;
            $display("FAIL win_prio got st=%0d lives=%0d go=%b want 3 1 0", st[0], lv[0], go[0]); end
        vectors++;
        if (resp != 0) begin miscompares++;
            $display("FAIL win_respawn got %0d pulses want 0", resp); end
        vectors++;
        if (st[1] !== 3'd4) begin miscompares++;
            $display("FAIL win_over_dut1 got st=%0d want 4", st[1]); end
    endtask

    task automatic test_reset_dying();
        int resp;
        new_game();
        press(2);
        repeat (3) tick();
        reset = 1'b0;
        model_reset();
        #1;
        resp = (rs[0] | rs[1]) ? 1 : 0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        repeat (12) begin tick(); if (rs[0] | rs[1]) resp++; end
        vectors++;
        if ({st[0], lv[0], h0[0]} !== {3'd0, 2'd3, 7'b1000000}) begin miscompares++;
            $display("FAIL rst_dying got st=%0d lives=%0d hex0=%b want 0 3 1000000",
                     st[0], lv[0], h0[0]); end
        vectors++;
        if (resp != 0) begin miscompares++;
            $display("FAIL rst_dying_respawn got %0d pulses want 0", resp); end
    endtask

    task automatic test_saturation();
        new_game();
        repeat (1110) press(1);
        vectors++;
        if ({h3[1], h2[1], h1[1], h0[1]} !== {7'b0010000, 7'b0010000, 7'b0010000, 7'b1000000})
        begin miscompares++;
            $display("FAIL sat_9990 got %b %b %b %b", h3[1], h2[1], h1[1], h0[1]); end
        press(1);
        vectors++;
        if ({h3[1], h2[1], h1[1], h0[1]} !== {4{7'b0010000}}) begin miscompares++;
            $display("FAIL sat_9999 got %b %b %b %b", h3[1], h2[1], h1[1], h0[1]); end
        repeat (3) press(1);
        vectors++;
        if ({h3[1], h2[1], h1[1], h0[1]} !== {4{7'b0010000}}) begin miscompares++;
            $display("FAIL sat_hold got %b %b %b %b", h3[1], h2[1], h1[1], h0[1]); end
        vectors++;
        if ({h3[0], h2[0], h1[0], h0[0]} !== {7'b1111001, 7'b1111001, 7'b1111001, 7'b0011001})
        begin miscompares++;
            $display("FAIL sat_dut0_1114 got %b %b %b %b", h3[0], h2[0], h1[0], h0[0]); end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 700; c++) begin
            if ($urandom_range(0, 249) == 0) do_reset();
            start   = ($urandom_range(0, 19) == 0);
            pellet  = $urandom_range(0, 1) == 1;
            caught  = ($urandom_range(0, 11) == 0);
            gamewin = ($urandom_range(0, 59) == 0);
            tick();
            for (int i = 0; i < 2; i++) begin
                vectors++;
                if (st[i] !== 3'(m_state[i])) begin miscompares++;
                    $display("FAIL rand_state dut%0d cyc %0d got %0d want %0d", i, c, st[i], m_state[i]); end
                vectors++;
                if (lv[i] !== 2'(m_lives[i]) || h5[i] !== seg(m_lives[i])) begin miscompares++;
                    $display("FAIL rand_lives dut%0d cyc %0d got %0d/%b want %0d", i, c, lv[i], h5[i], m_lives[i]); end
                vectors++;
                if (rs[i] !== exp_rs(i)) begin miscompares++;
                    $display("FAIL rand_respawn dut%0d cyc %0d got %b want %b", i, c, rs[i], exp_rs(i)); end
                vectors++;
                if (go[i] !== (m_state[i] == 4)) begin miscompares++;
                    $display("FAIL rand_over dut%0d cyc %0d got %b want %b", i, c, go[i], m_state[i] == 4); end
                vectors++;
                if ({h3[i], h2[i], h1[i], h0[i], h4[i]} !== {exp_hex(m_score[i], 3),
                    exp_hex(m_score[i], 2), exp_hex(m_score[i], 1), exp_hex(m_score[i], 0), 7'h7f})
                begin miscompares++;
                    $display("FAIL rand_score dut%0d cyc %0d got %b %b %b %b hex4=%b want score %0d",
                             i, c, h3[i], h2[i], h1[i], h0[i], h4[i], m_score[i]); end
            end
        end
        start = 1'b0; pellet = 1'b0; caught = 1'b0; gamewin = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_pellets();
        test_death();
        test_game_over();
        test_win_priority();
        test_reset_dying();
        test_saturation();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
